// File: rtl/sram_arb_512x128.sv
// Two-port round-robin arbiter in front of one single-port SRAM with a
// registered read output; each port holds one read response in a slot.
module sram_arb_512x128 #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wen,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_rdata,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wen,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_rdata,

  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } slot_t;

  slot_t slot0;
  slot_t slot1;
  logic  rr;

  logic  elig0;
  logic  elig1;
  logic  gnt0;
  logic  gnt1;
  logic  rd0;
  logic  rd1;
  slot_t slot0_nxt;
  slot_t slot1_nxt;

  // A read needs a free slot, or a full one being drained this cycle.
  function automatic slot_t slot_next(
    input slot_t s,
    input logic  rd,
    input logic  take
  );
    slot_t n;
    n = s;
    unique case (s)
      EMPTY:   n = rd ? PENDING : EMPTY;
      PENDING: n = FULL;
      FULL: begin
        if (take) begin
          n = rd ? PENDING : EMPTY;
        end
      end
      default: n = EMPTY;
    endcase
    return n;
  endfunction

  always_comb begin
    elig0 = req0_valid &
            (req0_wen | (slot0 == EMPTY) |
             ((slot0 == FULL) & resp0_ready));
    elig1 = req1_valid &
            (req1_wen | (slot1 == EMPTY) |
             ((slot1 == FULL) & resp1_ready));
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (elig0 & elig1) begin
        gnt0 = ~rr;
        gnt1 = rr;
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rd0        = gnt0 & ~req0_wen;
  assign rd1        = gnt1 & ~req1_wen;
  assign sram_oeb   = 1'b0;

  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_i   = '0;
    unique case (1'b1)
      gnt0: begin
        sram_csb = 1'b0;
        sram_web = ~req0_wen;
        sram_a   = req0_addr;
        sram_i   = req0_wdata;
      end
      gnt1: begin
        sram_csb = 1'b0;
        sram_web = ~req1_wen;
        sram_a   = req1_addr;
        sram_i   = req1_wdata;
      end
      default: begin
        sram_csb = 1'b1;
      end
    endcase
  end

  always_comb begin
    slot0_nxt = slot_next(slot0, rd0, resp0_ready);
    slot1_nxt = slot_next(slot1, rd1, resp1_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr          <= 1'b0;
      slot0       <= EMPTY;
      slot1       <= EMPTY;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
    end else begin
      if (gnt0) begin
        rr <= 1'b1;
      end else if (gnt1) begin
        rr <= 1'b0;
      end
      slot0       <= slot0_nxt;
      slot1       <= slot1_nxt;
      resp0_valid <= (slot0_nxt == FULL);
      resp1_valid <= (slot1_nxt == FULL);
      // SRAM output is valid the cycle after the read was sampled.
      if (slot0 == PENDING) begin
        resp0_rdata <= sram_o;
      end
      if (slot1 == PENDING) begin
        resp1_rdata <= sram_o;
      end
    end
  end

endmodule
